// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, FIFO depth and status bit positions.
package uart_pkg;

  localparam int UART_FIFO_DEPTH  = 4;
  localparam int UART_ST_RX_READY = 0;
  localparam int UART_ST_TX_DONE  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Four-entry circular byte FIFO for the UART receiver; pop on empty is ignored,
// push on full is dropped unless a pop frees a slot on the same edge.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [UART_FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(UART_FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive buffer and sticky error flags.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int F_CLK = 12_000_000,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       ready,
  output logic       cts,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = F_CLK / BAUD;
  localparam int CW  = (DIV < 4) ? 2 : $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: F_CLK/BAUD must be at least 4");
  end

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
  logic          ferr;
  logic          drop;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  // push/ferr are one-cycle pulses registered at the stop-bit sample, so the
  // buffer and flags update one clock after that sample.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      push    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      push <= 1'b0;
      ferr <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= FULL;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s) push <= 1'b1;
            else      ferr <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] head;
  logic [2:0] count;
  logic       full;
  logic       empty;

  uart_rx_fifo u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (rd),
    .din     (shreg),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign ready = !empty;
  assign cts   = (count == 3'(UART_FIFO_DEPTH));
  assign data  = ready ? head : 8'h00;
  assign drop  = push && full && !rd;
`else
  logic [7:0] hold;
  logic       valid;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hold  <= 8'h00;
      valid <= 1'b0;
    end else if (push && (!valid || rd)) begin
      hold  <= shreg;
      valid <= 1'b1;
    end else if (rd && valid) begin
      valid <= 1'b0;
    end
  end

  assign ready = valid;
  assign cts   = valid;
  assign data  = valid ? hold : 8'h00;
  assign drop  = push && valid && !rd;
`endif

  // A set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr | (frame_err & ~clr_err);
      overrun   <= drop | (overrun & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=16: frame-level reference model plus
// directed literal checks; build with or without UART_RX_FIFO_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int F_CLK = 16_000_000;
  localparam int BAUD  = 1_000_000;
  localparam int DIV   = F_CLK / BAUD;
  // rx fall to visible push: 2 sync + 1 edge detect, half bit, 8 data bits, stop bit, 1 register
  localparam int LAT   = 3 + DIV / 2 + 8 * DIV + DIV + 1;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       cts;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(.F_CLK(F_CLK), .BAUD(BAUD)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .data      (data),
    .ready     (ready),
    .cts       (cts),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame sent at cycle N yields its byte (or a frame error)
  // at cycle N+LAT; the buffer is a bounded queue with pop-before-push semantics.
  logic [7:0] exp_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  int         cyc = 0;
  bit         ev_valid = 1'b0;
  int         ev_cyc = 0;
  logic [7:0] ev_byte = 8'h00;
  bit         ev_ok = 1'b0;

  always @(posedge clk or negedge n_reset) begin : p_model
    bit fire;
    bit ovr_set;
    bit ferr_set;
    if (!n_reset) begin
      exp_q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      cyc++;
      fire     = ev_valid && (ev_cyc == cyc);
      ovr_set  = 1'b0;
      ferr_set = fire && !ev_ok;
      if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fire && ev_ok) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ev_byte);
        else                      ovr_set = 1'b1;
      end
      if (clr_err) begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      if (ferr_set) m_ferr = 1'b1;
      if (ovr_set)  m_ovr  = 1'b1;
    end
  end

  always @(negedge clk) begin : p_compare
    logic [7:0] e_data;
    if (n_reset) begin
      e_data = 8'h00;
      if (exp_q.size() > 0) e_data = exp_q[0];
      check("cyc_ready", ready, exp_q.size() > 0);
      check("cyc_data", data, e_data);
      check("cyc_cts", cts, exp_q.size() == DEPTH);
      check("cyc_frame_err", frame_err, m_ferr);
      check("cyc_overrun", overrun, m_ovr);
    end
  end

  task automatic hold(input logic val, input int n);
    rx = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(negedge clk);
    ev_byte  = b;
    ev_ok    = stop;
    ev_cyc   = cyc + LAT;
    ev_valid = 1'b1;
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop, DIV);
    rx = 1'b1;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Raise the requested strobes for exactly the edge on which the pending frame lands.
  task automatic strobe_on_push(input bit do_rd, input bit do_clr);
    int guard = 0;
    @(negedge clk);
    while (!(ev_valid && cyc == ev_cyc - 1) && guard < 4 * LAT) begin
      @(negedge clk);
      guard++;
    end
    check("strobe_timeout", guard < 4 * LAT, 1'b1);
    rd      = do_rd;
    clr_err = do_clr;
    @(negedge clk);
    rd      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_data"}, data, 8'h00);
    check({tag, "_cts"}, cts, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
  endtask

  logic [7:0] exp_lit[$];

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    #2 n_reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame at random phase, then pop
    repeat ($urandom_range(0, DIV - 1)) @(negedge clk);
    send_frame(8'h05, 1'b1);
    check("f05_ready", ready, 1'b1);
    check("f05_data", data, 8'h05);
    pulse_rd();
    check("pop_ready", ready, 1'b0);
    check("pop_data", data, 8'h00);
    pulse_rd();
    check("pop_empty_ignored", ready, 1'b0);

    // Start-bit glitch
    @(negedge clk);
    hold(1'b0, 4);
    hold(1'b1, DIV);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_ready", ready, 1'b0);
    check("glitch_frame_err", frame_err, 1'b0);

    // Stop bit low
    send_frame(8'hA5, 1'b0);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_ready", ready, 1'b0);
    pulse_clr();
    check("ferr_clr", frame_err, 1'b0);

    // Overrun on a full buffer
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovr_data", data, 8'h01);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_cts", cts, 1'b1);
    exp_lit = '{8'h01, 8'h02, 8'h03, 8'h04};
`else
    send_frame(8'h05, 1'b1);
    send_frame(8'h50, 1'b1);
    check("ovr_data", data, 8'h05);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_cts", cts, 1'b1);
    exp_lit = '{8'h05};
`endif
    foreach (exp_lit[i]) begin
      check("ovr_drain", data, exp_lit[i]);
      pulse_rd();
    end
    check("ovr_drained", ready, 1'b0);
    check("ovr_cts_empty", cts, 1'b0);

    // Frame error set on the same edge as clr_err: set wins
    fork
      send_frame(8'h3C, 1'b0);
      strobe_on_push(1'b0, 1'b1);
    join
    check("setwins_ferr", frame_err, 1'b1);
    check("setwins_ovr_cleared", overrun, 1'b0);
    pulse_clr();
    check("clr_ferr", frame_err, 1'b0);

    // Push with rd on a full buffer
`ifdef UART_RX_FIFO_EN
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    exp_lit = '{8'h22, 8'h33, 8'h44, 8'h99};
`else
    send_frame(8'h11, 1'b1);
    exp_lit = '{8'h99};
`endif
    check("full_cts", cts, 1'b1);
    fork
      send_frame(8'h99, 1'b1);
      strobe_on_push(1'b1, 1'b0);
    join
    check("pushpop_ovr", overrun, 1'b0);
    check("pushpop_cts", cts, 1'b1);
    foreach (exp_lit[i]) begin
      check("pushpop_drain", data, exp_lit[i]);
      pulse_rd();
    end
    check("pushpop_empty", ready, 1'b0);

    // Reset in the middle of data bit 3 with a byte stored
    send_frame(8'h33, 1'b1);
    check("pre_reset_ready", ready, 1'b1);
    @(negedge clk);
    hold(1'b0, DIV);
    hold(1'b0, DIV);
    hold(1'b1, DIV);
    hold(1'b0, DIV);
    hold(1'b1, DIV / 2);
    #2 n_reset = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_state", 32'(dut.state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b1;
    repeat (DIV) @(negedge clk);
    check("post_reset_ready", ready, 1'b0);
    send_frame(8'h50, 1'b1);
    check("post_reset_data", data, 8'h50);
    check("post_reset_rdy", ready, 1'b1);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
